// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM states, word-length codes,
// default oversampling ratio and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    localparam int OVERSAMPLE_DEF = 16;

    // Sticky parity sends the inverse of eps; otherwise eps picks even (XOR) or odd (XNOR).
    function automatic logic parity(input logic [7:0] data, input logic [1:0] wls,
                                    input logic eps, input logic sticky);
        logic [7:0] mask;
        logic       x;
        mask = 8'hFF >> (2'd3 - wls);
        x    = ^(data & mask);
        if (sticky)
            return ~eps;
        return eps ? x : ~x;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Counts baud_pulse ticks within one serial bit and strobes bit_done on the
// last tick of the programmed bit length.
module uart_bit_timer #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             baud_pulse,
    input  logic [CNT_W-1:0] bit_len,
    output logic             bit_done
);

    logic [CNT_W-1:0] cnt;

    assign bit_done = baud_pulse && !clear && (cnt == bit_len - 1'b1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || clear || bit_done)
            cnt <= '0;
        else if (baud_pulse)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pulls words from the TX FIFO and shifts out
// start, 5-8 data bits LSB first, optional parity and 1/1.5/2 stop bits.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_pulse,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    output logic       fifo_pop,
    input  logic [1:0] wls,
    input  logic       stb,
    input  logic       pen,
    input  logic       eps,
    input  logic       sticky,
    input  logic       set_break,
    output logic       tx,
    output logic       tsr_empty
);

    localparam int CNT_W = $clog2(2 * OVERSAMPLE + 1);
    localparam logic [CNT_W-1:0] LEN_1  = CNT_W'(OVERSAMPLE);
    localparam logic [CNT_W-1:0] LEN_15 = CNT_W'(OVERSAMPLE * 3 / 2);
    localparam logic [CNT_W-1:0] LEN_2  = CNT_W'(OVERSAMPLE * 2);

    tx_state_e        state, state_n;
    logic [7:0]       shreg, shreg_n;
    logic [2:0]       bit_cnt, bit_cnt_n;
    logic [1:0]       wls_q;
    logic             stb_q, pen_q, par_q;
    logic             load, tx_next, bit_done;
    logic [CNT_W-1:0] bit_len;

    // Only the stop bit length depends on configuration; every other bit is one bit time.
    always_comb begin
        bit_len = LEN_1;
        if (state == STOP && stb_q)
            bit_len = (wls_q == WLS_5) ? LEN_15 : LEN_2;
    end

    uart_bit_timer #(.CNT_W(CNT_W)) u_bit_timer (
        .clk        (clk),
        .rst        (rst),
        .clear      (state == IDLE),
        .baud_pulse (baud_pulse),
        .bit_len    (bit_len),
        .bit_done   (bit_done)
    );

    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        load      = 1'b0;
        tx_next   = 1'b1;
        case (state)
            IDLE: if (!fifo_empty) load = 1'b1;
            START: if (bit_done) begin
                state_n   = DATA;
                bit_cnt_n = '0;
            end
            DATA: if (bit_done) begin
                if (bit_cnt == {1'b0, wls_q} + 3'd4) begin
                    state_n = pen_q ? PARITY : STOP;
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                    shreg_n   = shreg >> 1;
                end
            end
            PARITY: if (bit_done) state_n = STOP;
            STOP: if (bit_done) begin
                if (!fifo_empty) load = 1'b1;
                else             state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (load) begin
            state_n   = START;
            shreg_n   = fifo_dout;
            bit_cnt_n = '0;
        end
        // Line level follows the state being entered so tx stays a plain register.
        case (state_n)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shreg_n[0];
            PARITY:  tx_next = par_q;
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            wls_q     <= WLS_5;
            stb_q     <= 1'b0;
            pen_q     <= 1'b0;
            par_q     <= 1'b0;
            tx        <= 1'b1;
            fifo_pop  <= 1'b0;
            tsr_empty <= 1'b1;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            bit_cnt   <= bit_cnt_n;
            tx        <= set_break ? 1'b0 : tx_next;
            fifo_pop  <= load;
            tsr_empty <= (state_n == IDLE);
            if (load) begin
                wls_q <= wls;
                stb_q <= stb;
                pen_q <= pen;
                par_q <= parity(fifo_dout, wls, eps, sticky);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: frame shapes, parity modes, stop
// lengths, back-to-back frames, mid-frame reset and line break.
module tb_uart_tx_serializer;
    import uart_pkg::*;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_pulse = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_dout = 8'h00;
    logic       fifo_pop;
    logic [1:0] wls = 2'b11;
    logic       stb = 1'b0, pen = 1'b0, eps = 1'b0, sticky = 1'b0;
    logic       set_break = 1'b0;
    logic       tx, tsr_empty;

    uart_tx_serializer #(.OVERSAMPLE(OS)) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_pulse (baud_pulse),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_pop   (fifo_pop),
        .wls        (wls),
        .stb        (stb),
        .pen        (pen),
        .eps        (eps),
        .sticky     (sticky),
        .set_break  (set_break),
        .tx         (tx),
        .tsr_empty  (tsr_empty)
    );

    always #5 clk = ~clk;

    logic [7:0] fifo_q[$];
    int n_pass = 0, n_total = 0;
    int div = 1, div_cnt = 0;
    int gtick = 0, pop_count = 0, pop_viol = 0;
    int brk_from = 0, brk_len = 0, brk_clks = 0;
    logic brk_q = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    // Advance one clk; model the FIFO, the baud divider and the break window.
    task automatic step();
        logic bp, bk, pop_pending;
        bp = baud_pulse;
        bk = set_break;
        pop_pending = fifo_pop;
        @(posedge clk);
        #1;
        if (bp) gtick++;
        if (bk) brk_clks++;
        brk_q = bk;
        if (pop_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
        fifo_empty = (fifo_q.size() == 0);
        fifo_dout  = fifo_empty ? 8'h00 : fifo_q[0];
        if (fifo_pop) begin
            pop_count++;
            if (fifo_empty) pop_viol++;
        end
        baud_pulse = (div_cnt == 0);
        div_cnt    = (div_cnt + 1 >= div) ? 0 : div_cnt + 1;
        set_break  = (brk_len > 0) && (gtick >= brk_from) && (gtick < brk_from + brk_len);
    endtask

    task automatic push(input logic [7:0] d);
        fifo_q.push_back(d);
        fifo_empty = 1'b0;
        fifo_dout  = fifo_q[0];
    endtask

    // Hold one bit for 'ticks' baud ticks; tx must match (or be 0 under break), frame busy throughout.
    task automatic run_bit(input logic exp, input int ticks, input string tag);
        int t = 0, guard = 0;
        logic [1:0] obs, want, e;
        bit bad = 0;
        want = {1'b0, exp};
        obs  = want;
        while (t < ticks && guard < ticks * div * 2 + 10) begin
            e = {1'b0, brk_q ? 1'b0 : exp};
            if ({tsr_empty, tx} !== e && !bad) begin
                bad  = 1;
                obs  = {tsr_empty, tx};
                want = e;
            end
            if (baud_pulse) t++;
            step();
            guard++;
        end
        check(tag, obs, want);
        if (t < ticks) check({tag, "_timeout"}, t, ticks);
    endtask

    // seq lists the start/data/parity bits in transmit order, first bit leftmost.
    task automatic expect_frame(input logic [15:0] seq, input int n, input int stop_ticks,
                                input bit do_load, input string tag);
        if (do_load) step();
        for (int i = 0; i < n; i++)
            run_bit(seq[n-1-i], OS, $sformatf("%s_b%0d", tag, i));
        run_bit(1'b1, stop_ticks, {tag, "_stop"});
    endtask

    task automatic expect_idle(input string tag);
        check(tag, {tsr_empty, tx}, 2'b11);
    endtask

    initial begin
        int pc0;
        repeat (3) step();
        check("rst_tx", tx, 1);
        check("rst_tsr_empty", tsr_empty, 1);
        check("rst_pop", fifo_pop, 0);
        rst = 1'b0;
        step();

        // 8N1 0xA5, baud_pulse held high
        div = 1;
        pc0 = pop_count;
        wls = 2'b11; pen = 0; stb = 0;
        push(8'hA5);
        expect_frame(16'b0_1010_0101, 9, 16, 1, "a5");
        expect_idle("a5_idle");
        check("a5_pops", pop_count - pc0, 1);

        // 5 bits, even parity, 1.5 stop; config changed right after load must not matter
        div = 3;
        pc0 = pop_count;
        wls = 2'b00; pen = 1; eps = 1; sticky = 0; stb = 1;
        push(8'h13);
        step();
        wls = 2'b11; pen = 0; stb = 0; eps = 0;
        expect_frame(16'b0_11001_1, 7, 24, 0, "p13");
        expect_idle("p13_idle");
        check("p13_pops", pop_count - pc0, 1);

        // Sticky parity: eps=1 -> 0, eps=0 -> 1
        wls = 2'b11; pen = 1; sticky = 1; eps = 1; stb = 0;
        push(8'hFF);
        expect_frame(16'b0_11111111_0, 10, 16, 1, "stk1");
        expect_idle("stk1_idle");
        eps = 0;
        push(8'hFF);
        expect_frame(16'b0_11111111_1, 10, 16, 1, "stk0");
        expect_idle("stk0_idle");

        // Three queued words, back-to-back with no idle bit
        div = 2;
        pc0 = pop_count;
        pen = 0; sticky = 0; stb = 0; wls = 2'b11;
        push(8'h01); push(8'h02); push(8'h03);
        expect_frame(16'b0_10000000, 9, 16, 1, "b2b1");
        expect_frame(16'b0_01000000, 9, 16, 0, "b2b2");
        expect_frame(16'b0_11000000, 9, 16, 0, "b2b3");
        expect_idle("b2b_idle");
        check("b2b_pops", pop_count - pc0, 3);

        // Reset in the middle of a data bit
        div = 1;
        pc0 = pop_count;
        push(8'h55);
        step();
        run_bit(1'b0, OS, "rst55_start");
        run_bit(1'b1, OS, "rst55_b0");
        run_bit(1'b0, OS, "rst55_b1");
        repeat (5) step();
        rst = 1'b1;
        step();
        check("midrst_tx", tx, 1);
        check("midrst_state", dut.state, 32'(IDLE));
        check("midrst_pop", fifo_pop, 0);
        check("midrst_tsr", tsr_empty, 1);
        rst = 1'b0;
        step();
        check("midrst_pops", pop_count - pc0, 1);
        push(8'h55);
        expect_frame(16'b0_10101010, 9, 16, 1, "clean55");
        expect_idle("clean55_idle");

        // 40-tick break starting mid-frame
        pc0 = pop_count;
        brk_clks = 0;
        brk_from = gtick + 41;
        brk_len  = 40;
        push(8'hA5);
        expect_frame(16'b0_1010_0101, 9, 16, 1, "brk");
        expect_idle("brk_idle");
        check("brk_len", brk_clks, 40);
        check("brk_pops", pop_count - pc0, 1);
        brk_len = 0;

        check("pop_while_empty", pop_viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
